// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter and sequencer for the shared ALU.
// A winning request's opcode and operands are registered and held on the
// combinational ALU for a fixed per-opcode number of cycles. The result is
// then returned with the requester ID over a valid/ready response channel.
// Only one operation is in flight at a time.

module alu_arbiter #(
  parameter int unsigned MULDIV_CYCLES = 3,   // EXEC cycles for mul/div, 1..15
  parameter int unsigned WIDTH         = 19   // must equal the ALU width
) (
  input  logic             clk,
  input  logic             rst,

  // Requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [4:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,

  // Requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [4:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,

  // Shared combinational ALU
  output logic [4:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,

  // Response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [4:0] OP_MUL     = 5'b00011;
  localparam logic [4:0] OP_DIV     = 5'b00100;
  localparam logic [3:0] MULDIV_CNT = 4'(MULDIV_CYCLES);

  // Mul/div get the long hold so they can be timed as multicycle paths.
  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // Legal set: 1..10, 15 and 16. Anything else still executes but is flagged.
  function automatic logic is_legal(input logic [4:0] op);
    return ((op >= 5'd1) && (op <= 5'd10)) || (op == 5'd15) || (op == 5'd16);
  endfunction

  state_e           state_q,      state_d;
  logic [3:0]       cnt_q,        cnt_d;
  logic             last_grant_q, last_grant_d;
  logic [4:0]       op_q,         op_d;
  logic [WIDTH-1:0] a_q,          a_d;
  logic [WIDTH-1:0] b_q,          b_d;
  logic             id_q,         id_d;
  logic [WIDTH-1:0] result_q,     result_d;
  logic             err_q,        err_d;

  logic             gnt0;
  logic             gnt1;

  // Round-robin grant: a lone requester wins, a tie goes to the one that was
  // not granted last. Nothing is granted outside IDLE or while in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if ((state_q == S_IDLE) && !rst) begin
      if (req0_valid && (!req1_valid || last_grant_q)) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Next-state and datapath capture for the IDLE -> EXEC -> RESP sequence.
  // NOTE: every _d gets its hold value first, so no path through the case
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    result_d     = result_q;
    err_d        = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (gnt0 || gnt1) begin
          op_d         = gnt1 ? req1_op : req0_op;
          a_d          = gnt1 ? req1_a  : req0_a;
          b_d          = gnt1 ? req1_b  : req0_b;
          id_d         = gnt1;
          last_grant_d = gnt1;
          cnt_d        = is_muldiv(gnt1 ? req1_op : req0_op) ? MULDIV_CNT : 4'd1;
          state_d      = S_EXEC;
        end
      end

      S_EXEC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          result_d = alu_result;
          err_d    = !is_legal(op_q);
          state_d  = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      op_q         <= 5'd0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      result_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      result_q     <= result_d;
      err_q        <= err_d;
    end
  end

  // The ALU only sees the latched operation during EXEC; otherwise it idles
  // on opcode 0 with zero operands.
  always_comb begin
    alu_ctrl = 5'd0;
    alu_a    = '0;
    alu_b    = '0;
    if (state_q == S_EXEC) begin
      alu_ctrl = op_q;
      alu_a    = a_q;
      alu_b    = b_q;
    end
  end

  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter. A stimulus task drives requests and a
// transaction-level model of the arbiter decides grants and pushes expected
// responses into a scoreboard queue. A separate monitor pops and compares
// whenever the DUT presents a response.

module tb_alu_arbiter;

  localparam int W = 19;
  localparam int K = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]   alu_ctrl;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [W-1:0] rsp_result;

  always #5 clk = ~clk;

  alu_arbiter #(.MULDIV_CYCLES(K), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err)
  );

  // Behavioural ALU: illegal opcodes (and opcode 0) return 0, div by 0 gives 0.
  function automatic logic [W-1:0] alu_fn(input logic [4:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      5'd1:    return a + b;
      5'd2:    return a - b;
      5'd3:    return p[W-1:0];
      5'd4:    return (b == '0) ? '0 : a / b;
      5'd5:    return a & b;
      5'd6:    return a | b;
      5'd7:    return a ^ b;
      5'd8:    return a << b[4:0];
      5'd9:    return a >> b[4:0];
      5'd10:   return {{(W-1){1'b0}}, (a < b)};
      5'd15:   return a;
      5'd16:   return b;
      default: return '0;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_ctrl, alu_a, alu_b);

  function automatic logic legal(input logic [4:0] op);
    return (op inside {[5'd1:5'd10], 5'd15, 5'd16});
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic         id;
    logic [W-1:0] result;
    logic         err;
    int           cyc;
  } rsp_t;

  rsp_t sb_q[$];

  // Transaction-level model: busy from an accept until the response is taken.
  logic         m_idle = 1'b1;
  logic         m_last = 1'b1;
  int           m_acc  = 0;
  int           m_k    = 1;
  logic [4:0]   m_op   = '0;
  logic [W-1:0] m_a    = '0;
  logic [W-1:0] m_b    = '0;

  task automatic step(input logic v0, input logic [4:0] o0, input logic [W-1:0] a0,
                      input logic [W-1:0] b0, input logic v1, input logic [4:0] o1,
                      input logic [W-1:0] a1, input logic [W-1:0] b1, input logic rr);
    logic e0, e1, ex;
    int   n;
    rsp_t r;
    @(negedge clk);
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    rsp_ready  = rr;
    #1;
    n  = cyc;
    e0 = m_idle && v0 && (!v1 || m_last);
    e1 = m_idle && v1 && (!v0 || !m_last);
    check("req0_ready", 32'(req0_ready), 32'(e0));
    check("req1_ready", 32'(req1_ready), 32'(e1));
    ex = !m_idle && (n > m_acc) && (n <= m_acc + m_k);
    check("alu_ctrl", 32'(alu_ctrl), ex ? 32'(m_op) : 32'd0);
    check("alu_a",    32'(alu_a),    ex ? 32'(m_a)  : 32'd0);
    check("alu_b",    32'(alu_b),    ex ? 32'(m_b)  : 32'd0);
    if (e0 || e1) begin
      m_op   = e1 ? o1 : o0;
      m_a    = e1 ? a1 : a0;
      m_b    = e1 ? b1 : b0;
      m_k    = (m_op == 5'd3 || m_op == 5'd4) ? K : 1;
      m_acc  = n;
      m_last = e1;
      m_idle = 1'b0;
      r.id     = e1;
      r.result = alu_fn(m_op, m_a, m_b);
      r.err    = !legal(m_op);
      r.cyc    = n + m_k + 1;
      sb_q.push_back(r);
    end else if (!m_idle && (n >= m_acc + m_k + 1) && rr) begin
      m_idle = 1'b1;
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, '0, '0, '0, 0, '0, '0, '0, 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    check("rst_rsp_id",     32'(rsp_id),     32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_rsp_err",    32'(rsp_err),    32'd0);
    check("rst_alu_ctrl",   32'(alu_ctrl),   32'd0);
    check("rst_alu_a",      32'(alu_a),      32'd0);
    check("rst_alu_b",      32'(alu_b),      32'd0);
  endtask

  // Monitor: pops on each new response, then checks it stays stable while held.
  initial begin
    rsp_t cur;
    logic fresh;
    fresh = 1'b1;
    cur   = '{id: 1'b0, result: '0, err: 1'b0, cyc: 0};
    forever begin
      @(negedge clk);
      #2;
      if (rsp_valid) begin
        if (fresh) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got id=%0d result=%0h with nothing expected (cycle %0d)",
                     rsp_id, rsp_result, cyc);
          end else begin
            cur = sb_q.pop_front();
            check("rsp_cycle", 32'(cyc), 32'(cur.cyc));
          end
          fresh = 1'b0;
        end
        check("rsp_id",     32'(rsp_id),     32'(cur.id));
        check("rsp_result", 32'(rsp_result), 32'(cur.result));
        check("rsp_err",    32'(rsp_err),    32'(cur.err));
        if (rsp_ready) fresh = 1'b1;
      end else begin
        fresh = 1'b1;
      end
    end
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req0_op = 5'd1; req0_a = '0; req0_b = '0;
    req1_valid = 1'b1; req1_op = 5'd1; req1_a = '0; req1_b = '0;
    rsp_ready  = 1'b1;
    #3;
    check_reset_outputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Tie arbitration: grants alternate 0,1,0,1 with accepts 3 cycles apart.
    for (int i = 0; i < 12; i++) step(1, 5'd1, 19'd10, 19'd1, 1, 5'd2, 19'd10, 19'd1, 1);
    idle(3);

    // Single add.
    step(1, 5'd1, 19'd5, 19'd7, 0, '0, '0, '0, 1);
    idle(3);

    // Multicycle divide, then divide by zero.
    step(0, '0, '0, '0, 1, 5'd4, 19'd100, 19'd7, 1);
    idle(5);
    step(0, '0, '0, '0, 1, 5'd4, 19'd100, 19'd0, 1);
    idle(5);

    // Wrap-around and illegal opcode.
    step(1, 5'd1, 19'h7FFFF, 19'd1, 0, '0, '0, '0, 1);
    idle(3);
    step(1, 5'b01011, 19'd3, 19'd4, 0, '0, '0, '0, 1);
    idle(3);

    // Backpressure: response held while both requesters toggle.
    step(1, 5'd1, 19'd3, 19'd4, 0, '0, '0, '0, 0);
    for (int i = 0; i < 8; i++) begin
      step(i[0], 5'd2, 19'd9, 19'd1, !i[0], 5'd6, 19'd1, 19'd2, 0);
    end
    step(0, '0, '0, '0, 0, '0, '0, '0, 1);
    idle(2);

    // Reset during the second EXEC cycle of a multiply.
    idle(2);
    step(1, 5'd3, 19'd6, 19'd7, 0, '0, '0, '0, 1);
    step(0, '0, '0, '0, 0, '0, '0, '0, 1);
    @(negedge clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    sb_q.delete();
    m_idle = 1'b1;
    m_last = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    step(1, 5'd1, 19'd1, 19'd1, 1, 5'd1, 19'd2, 19'd2, 1);
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [W-1:0] b0, b1;
      b0 = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      b1 = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 17)), W'($urandom), b0,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 17)), W'($urandom), b1,
           ($urandom_range(0, 3) != 0));
    end

    idle(10);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
